prog_truth_table: RTL and testbench
===================================

// Module: prog_truth_table
// PURPOSE
//   Run-time programmable truth-table evaluator: N_OUT boolean functions of N_IN inputs, held as a
//   2**N_IN x N_OUT table loaded one minterm per beat. Replaces fixed per-table combinational modules
//   with one registered, reloadable block. Sits between the lab switch/stimulus logic and the LED/display outputs.
// PARAMETERS
//   N_IN   3  number of function inputs; DEPTH = 2**N_IN minterms (legal 1..8)
//   N_OUT  2  number of independent output functions (legal 1..16)
// PORTS
//   clk        in   1      single clock; all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   cfg_start  in   1      pulse: begin (re)load of table at minterm 0
//   cfg_valid  in   1      cfg_data beat valid
//   cfg_data   in   N_OUT  outputs for current minterm (bit k = function k)
//   cfg_ready  out  1      high only in LOAD
//   cfg_done   out  1      1-cycle pulse, cycle after last minterm written
//   eval_valid in   1      evaluate eval_in this cycle
//   eval_in    in   N_IN   input vector; MSB = first variable (A)
//   eval_ready out  1      high only in RUN
//   y          out  N_OUT  registered function outputs
//   y_valid    out  1      y updated this cycle
//   y_idx      out  N_IN   minterm index that produced y
//   sweep_go   in   1      start self-sweep (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: state EMPTY, table all 0, load index 0, cfg_ready=0, cfg_done=0, eval_ready=0, y=0, y_valid=0, y_idx=0.
//   - FSM EMPTY/LOAD/RUN/SWEEP. cfg_start in any state -> LOAD, index 0 (restarts a partial load).
//   - LOAD: each cfg_valid beat writes cfg_data at index, index++. Write at index DEPTH-1 -> RUN, cfg_done next cycle.
//     cfg_valid outside LOAD ignored. cfg_start and cfg_valid same cycle: start wins, data dropped.
//   - Reloading over RUN: old table contents persist until each entry is overwritten, but eval_ready=0 until load completes.
//   - RUN: eval_valid -> y = table[eval_in], y_idx = eval_in, y_valid = 1 exactly 1 cycle later. Back-to-back evals give one result per cycle.
//   - eval_valid while eval_ready=0 ignored (no y_valid). y/y_idx hold last value when y_valid=0.
//   - cfg_start while a RUN result is in flight: that result still emitted next cycle.
//   - Reset mid-LOAD or mid-SWEEP: immediate return to EMPTY, table cleared; table must be fully reloaded.
//   - Index counters N_IN bits wide; wrap never occurs (FSM leaves LOAD/SWEEP at DEPTH-1).
// CONFIGURATION
//   PTT_SWEEP_EN defined: in RUN, sweep_go -> SWEEP; emits table[0..DEPTH-1] on y, one per cycle, y_idx=minterm,
//     y_valid=1, first output cycle after sweep_go; eval_ready=0 in SWEEP; after idx DEPTH-1 -> RUN.
//     sweep_go and eval_valid same cycle: sweep wins, eval dropped. sweep_go outside RUN ignored.
//   PTT_SWEEP_EN undefined: sweep_go port present but ignored; SWEEP state and counter not built.
// STRUCTURE
//   - Package ptt_pkg: state enum ptt_state_t {EMPTY,LOAD,RUN,SWEEP}; function depth_of(n_in) = 1<<n_in.
//   - Sub-module ptt_table_mem: DEPTH x N_OUT register array, sync write port, registered read port,
//     sync clear on rst. Top holds FSM, counters and handshake.
// TESTING (bench N_IN=3, N_OUT=2; load cfg_data for minterms 0..7 = 11,01,10,00,11,11,00,01)
//   1. Reset then eval_valid with eval_in=101 -> no y_valid; eval_ready=0, y=00.
//   2. Full load, 8 beats with gaps -> cfg_done 1 cycle after 8th beat, eval_ready=1 same cycle.
//   3. Evals 101,110,000 on consecutive cycles -> y = 11,00,11, y_idx = 5,6,0, each 1 cycle later.
//   4. cfg_start after 4 beats, then 8 beats of 00 -> eval 111 yields y=00; no cfg_done from aborted load.
//   5. rst during LOAD at beat 3 -> EMPTY, cfg_ready=0; reload, eval 011 -> y=00.
//   6. (PTT_SWEEP_EN) sweep_go with eval_valid same cycle -> 8 consecutive y_valid, y_idx 0..7,
//      y = 11,01,10,00,11,11,00,01; eval dropped; eval_ready=1 after.

Source files
------------

// File: rtl/ptt_pkg.sv
// Shared types and helpers for the programmable truth-table evaluator.
package ptt_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        SWEEP = 2'd3
    } ptt_state_t;

    function automatic int depth_of(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/ptt_table_mem.sv
// DEPTH x N_OUT truth-table storage: synchronous write, registered read, cleared on rst.
module ptt_table_mem
    import ptt_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [N_IN-1:0]  wr_addr,
    input  logic [N_OUT-1:0] wr_data,
    input  logic             rd_en,
    input  logic [N_IN-1:0]  rd_addr,
    output logic [N_OUT-1:0] rd_data
);

    localparam int DEPTH = depth_of(N_IN);

    logic [N_OUT-1:0] mem [DEPTH];

    // rd_data only moves on a read, so it doubles as the held output value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/prog_truth_table.sv
// Reloadable registered truth-table evaluator: FSM, load/sweep counters and handshakes.
// Optional self-sweep of the whole table is built only when PTT_SWEEP_EN is defined.
//
// state | meaning
// EMPTY | no valid table since reset
// LOAD  | accepting cfg_data beats, one minterm per beat
// RUN   | table complete, evaluating eval_in
// SWEEP | emitting table[0..DEPTH-1] on y, one per cycle
module prog_truth_table
    import ptt_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic [N_OUT-1:0] cfg_data,
    output logic             cfg_ready,
    output logic             cfg_done,
    input  logic             eval_valid,
    input  logic [N_IN-1:0]  eval_in,
    output logic             eval_ready,
    output logic [N_OUT-1:0] y,
    output logic             y_valid,
    output logic [N_IN-1:0]  y_idx,
    input  logic             sweep_go
);

    localparam int              DEPTH = depth_of(N_IN);
    localparam logic [N_IN-1:0] LAST  = N_IN'(DEPTH - 1);

    ptt_state_t      state;
    logic [N_IN-1:0] idx;
    logic            wr_en;
    logic            rd_en;
    logic [N_IN-1:0] rd_addr;
    logic            sweep_fire;

`ifdef PTT_SWEEP_EN
    logic [N_IN-1:0] sw_idx;
`else
    logic sweep_unused;
    assign sweep_unused = sweep_go;
`endif

    assign cfg_ready  = (state == LOAD);
    assign eval_ready = (state == RUN);

    always_comb begin
        sweep_fire = 1'b0;
        wr_en      = (state == LOAD) && cfg_valid && !cfg_start;
        rd_en      = 1'b0;
        rd_addr    = eval_in;
`ifdef PTT_SWEEP_EN
        sweep_fire = (state == RUN) && sweep_go && !cfg_start;
`endif
        if (state == RUN && eval_valid && !sweep_fire) begin
            rd_en = 1'b1;
        end
`ifdef PTT_SWEEP_EN
        if (sweep_fire) begin
            rd_en   = 1'b1;
            rd_addr = '0;
        end else if (state == SWEEP && !cfg_start) begin
            rd_en   = 1'b1;
            rd_addr = sw_idx;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            idx      <= '0;
            cfg_done <= 1'b0;
            y_valid  <= 1'b0;
            y_idx    <= '0;
`ifdef PTT_SWEEP_EN
            sw_idx   <= '0;
`endif
        end else begin
            cfg_done <= 1'b0;
            y_valid  <= rd_en;
            if (rd_en) begin
                y_idx <= rd_addr;
            end
            // A restart takes priority over everything, including an active sweep.
            if (cfg_start) begin
                state <= LOAD;
                idx   <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        if (cfg_valid) begin
                            if (idx == LAST) begin
                                state    <= RUN;
                                cfg_done <= 1'b1;
                                idx      <= '0;
                            end else begin
                                idx <= idx + N_IN'(1);
                            end
                        end
                    end
`ifdef PTT_SWEEP_EN
                    RUN: begin
                        if (sweep_fire) begin
                            state  <= SWEEP;
                            sw_idx <= N_IN'(1);
                        end
                    end
                    SWEEP: begin
                        if (sw_idx == LAST) begin
                            state  <= RUN;
                            sw_idx <= '0;
                        end else begin
                            sw_idx <= sw_idx + N_IN'(1);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    ptt_table_mem #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (idx),
        .wr_data (cfg_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (y)
    );

endmodule

// File: tb/tb_prog_truth_table.sv
// Scoreboard bench for prog_truth_table (N_IN=3, N_OUT=2); sweep test runs when PTT_SWEEP_EN is defined.
module tb_prog_truth_table;

    typedef struct {
        logic [2:0] idx;
        logic [1:0] y;
        int         cyc;
    } exp_t;

    // minterm 0 in the low bits: 11,01,10,00,11,11,00,01
    localparam logic [15:0] TBL = 16'b01_00_11_11_00_10_01_11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_data = '0;
    logic       cfg_ready;
    logic       cfg_done;
    logic       eval_valid = 1'b0;
    logic [2:0] eval_in = '0;
    logic       eval_ready;
    logic [1:0] y;
    logic       y_valid;
    logic [2:0] y_idx;
    logic       sweep_go = 1'b0;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    exp_t q[$];

    prog_truth_table #(.N_IN(3), .N_OUT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .cfg_done   (cfg_done),
        .eval_valid (eval_valid),
        .eval_in    (eval_in),
        .eval_ready (eval_ready),
        .y          (y),
        .y_valid    (y_valid),
        .y_idx      (y_idx),
        .sweep_go   (sweep_go)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] idx, input logic [1:0] yv, input int dly);
        exp_t e;
        e.idx = idx;
        e.y   = yv;
        e.cyc = cyc + dly;
        q.push_back(e);
    endtask

    // Monitor: every y_valid must match the head of the scoreboard, on the expected cycle.
    always @(negedge clk) begin
        if (cfg_done) done_cnt++;
        if (y_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_y_valid: got y_idx=%0d y=%b expected no output (cycle %0d)",
                         y_idx, y, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("y_result {cyc,idx,y}", {27'd0, cyc[31:0], y_idx, y},
                      {27'd0, e.cyc[31:0], e.idx, e.y});
            end
        end
    end

    task automatic load_table(input logic [15:0] pack, input int n_beats, input bit gaps);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("cfg_ready_in_load", 64'(cfg_ready), 64'd1);
        check("eval_ready_in_load", 64'(eval_ready), 64'd0);
        for (int i = 0; i < n_beats; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = pack[2*i +: 2];
            tick();
            cfg_valid = 1'b0;
            if (gaps && i < n_beats - 1) tick();
        end
        if (n_beats == 8) begin
            @(negedge clk);
            check("cfg_done_pulse", 64'(cfg_done), 64'd1);
            check("eval_ready_after_load", 64'(eval_ready), 64'd1);
            check("cfg_ready_after_load", 64'(cfg_ready), 64'd0);
            tick();
            check("cfg_done_single", 64'(cfg_done), 64'd0);
        end
    endtask

    initial begin
        int d0;
        tick();
        tick();
        rst = 1'b0;

        // 1: reset state, evaluation ignored while EMPTY
        @(negedge clk);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("rst_cfg_done", 64'(cfg_done), 64'd0);
        check("rst_eval_ready", 64'(eval_ready), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_y_idx", 64'(y_idx), 64'd0);
        eval_valid = 1'b1;
        eval_in    = 3'b101;
        tick();
        eval_valid = 1'b0;
        @(negedge clk);
        check("empty_no_y_valid", 64'(y_valid), 64'd0);
        check("empty_y_held", 64'(y), 64'd0);
        tick();

        // 2: full load with gaps
        load_table(TBL, 8, 1'b1);

        // 3: back-to-back evaluations
        eval_valid = 1'b1;
        eval_in = 3'b101; push_exp(3'd5, 2'b11, 1); tick();
        eval_in = 3'b110; push_exp(3'd6, 2'b00, 1); tick();
        eval_in = 3'b000; push_exp(3'd0, 2'b11, 1); tick();
        eval_valid = 1'b0;
        tick();
        @(negedge clk);
        check("y_holds", 64'({y_idx, y}), 64'({3'd0, 2'b11}));
        tick();

        // 4: aborted load then full reload of zeros; eval in flight across cfg_start
        d0 = done_cnt;
        eval_valid = 1'b1;
        eval_in = 3'b100;
        push_exp(3'd4, 2'b11, 1);
        load_table(16'hFFFF, 4, 1'b0);
        eval_valid = 1'b0;
        eval_in = 3'b000;
        eval_valid = 1'b1;
        tick();
        eval_valid = 1'b0;
        tick();
        check("abort_no_cfg_done", 64'(done_cnt), 64'(d0));
        load_table(16'h0000, 8, 1'b1);
        check("reload_one_cfg_done", 64'(done_cnt), 64'(d0 + 1));
        eval_valid = 1'b1;
        eval_in = 3'b111; push_exp(3'd7, 2'b00, 1); tick();
        eval_in = 3'b000; push_exp(3'd0, 2'b00, 1); tick();
        eval_valid = 1'b0;
        tick();

        // 5: reset mid-load, then full reload
        load_table(TBL, 3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_cfg_ready", 64'(cfg_ready), 64'd0);
        check("rst_mid_eval_ready", 64'(eval_ready), 64'd0);
        check("rst_mid_y", 64'(y), 64'd0);
        tick();
        load_table(TBL, 8, 1'b0);
        eval_valid = 1'b1;
        eval_in = 3'b011; push_exp(3'd3, 2'b00, 1); tick();
        eval_in = 3'b000; push_exp(3'd0, 2'b11, 1); tick();
        eval_in = 3'b010; push_exp(3'd2, 2'b10, 1); tick();
        eval_valid = 1'b0;
        tick();

`ifdef PTT_SWEEP_EN
        // 6: sweep wins over a simultaneous eval
        sweep_go   = 1'b1;
        eval_valid = 1'b1;
        eval_in    = 3'b010;
        for (int i = 0; i < 8; i++) push_exp(3'(i), TBL[2*i +: 2], 1 + i);
        tick();
        sweep_go   = 1'b0;
        eval_valid = 1'b0;
        check("sweep_eval_ready_low", 64'(eval_ready), 64'd0);
        for (int i = 0; i < 8; i++) tick();
        check("sweep_eval_ready_back", 64'(eval_ready), 64'd1);
`endif

        tick();
        tick();
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
